// File: rtl/display.sv
// display: operand entry, result selection and time-multiplexed 7-segment scan for the two-operand calculator.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of arithmetic results.
module display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] B,
    output logic [6:0] mux_out,
    output logic [3:0] decoder_out
);
    localparam logic [3:0] CH_MINUS = 4'd10;
    localparam logic [3:0] CH_BLANK = 4'd11;
    localparam logic [3:0] CH_E     = 4'd12;
    localparam logic [3:0] CH_R     = 4'd13;

    logic [3:0]              digit_r [4];
    logic [3:0]              btn_prev_r;
    logic [REFRESH_BITS-1:0] cnt_r;
    logic [3:0]              rise_s;
    logic [6:0]              a_s;
    logic [6:0]              bv_s;
    logic [13:0]             value_s;
    logic                    negative_s;
    logic                    error_s;
    logic                    result_view_s;
    logic [15:0]             bcd_s;
    logic [3:0]              char_s [4];
    logic [1:0]              pos_s;
    logic [3:0]              char_sel_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lead_zero_s;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] seg;
        case (c)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            CH_MINUS: seg = 7'b0111111;
            CH_E:    seg = 7'b0000110;
            CH_R:    seg = 7'b0101111;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Shift-add-3 conversion; 14 bits covers the largest product, 9801.
    function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = 16'd0;
        for (int i = 13; i >= 0; i--) begin
            for (int n = 0; n < 4; n++) begin
                if (bcd[n*4 +: 4] >= 4'd5) bcd[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
                else bcd[n*4 +: 4] = bcd[n*4 +: 4];
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    assign rise_s = B[3:0] & ~btn_prev_r;
    assign a_s    = {3'd0, digit_r[0]} * 7'd10 + {3'd0, digit_r[1]};
    assign bv_s   = {3'd0, digit_r[2]} * 7'd10 + {3'd0, digit_r[3]};
    assign bcd_s  = bin2bcd(value_s);
    assign pos_s  = cnt_r[REFRESH_BITS-1 -: 2];
    assign char_sel_s = char_s[pos_s];

    // Digit entry; history follows B even in reset so a held button does not count on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) digit_r[i] <= 4'd0;
            btn_prev_r <= B[3:0];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rise_s[i]) digit_r[i] <= (digit_r[i] == 4'd9) ? 4'd0 : digit_r[i] + 4'd1;
                else digit_r[i] <= digit_r[i];
            end
            btn_prev_r <= B[3:0];
        end
    end

    // Arithmetic view selection, highest-numbered button wins.
    always_comb begin
        value_s       = 14'd0;
        negative_s    = 1'b0;
        error_s       = 1'b0;
        result_view_s = 1'b1;
        if (B[8]) begin
            result_view_s = 1'b0;
        end else if (B[7]) begin
            if (bv_s == 7'd0) error_s = 1'b1;
            else value_s = {7'd0, a_s / bv_s};
        end else if (B[6]) begin
            value_s = {7'd0, a_s} * {7'd0, bv_s};
        end else if (B[5]) begin
            if (a_s >= bv_s) begin
                value_s = {7'd0, a_s - bv_s};
            end else begin
                negative_s = 1'b1;
                value_s    = {7'd0, bv_s - a_s};
            end
        end else if (B[4]) begin
            value_s = {7'd0, a_s} + {7'd0, bv_s};
        end else begin
            result_view_s = 1'b0;
        end
    end

    // Character per position P0..P3 for the selected view.
    always_comb begin
        for (int p = 0; p < 4; p++) char_s[p] = digit_r[p];
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero_s = 1'b1;
`endif
        if (!result_view_s) begin
            for (int p = 0; p < 4; p++) char_s[p] = digit_r[p];
        end else if (error_s) begin
            char_s[0] = CH_BLANK;
            char_s[1] = CH_E;
            char_s[2] = CH_R;
            char_s[3] = CH_R;
        end else begin
            char_s[0] = negative_s ? CH_MINUS : bcd_s[15:12];
            char_s[1] = bcd_s[11:8];
            char_s[2] = bcd_s[7:4];
            char_s[3] = bcd_s[3:0];
`ifdef LEADING_ZERO_BLANK_EN
            for (int p = 0; p < 3; p++) begin
                if (lead_zero_s && char_s[p] == 4'd0) char_s[p] = CH_BLANK;
                else if (char_s[p] != CH_MINUS) lead_zero_s = 1'b0;
                else lead_zero_s = lead_zero_s;
            end
`endif
        end
    end

    // Scan counter and registered segment/anode pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {REFRESH_BITS{1'b0}};
            mux_out     <= 7'h7F;
            decoder_out <= 4'hF;
        end else begin
            cnt_r       <= cnt_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            mux_out     <= glyph(char_sel_s);
            decoder_out <= ~(4'b1000 >> pos_s);
        end
    end

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: directed calculator sessions plus random button traffic,
// compared every cycle against an arithmetic reference model of the displayed characters.
module tb_display;
    localparam int RB      = 4;
    localparam int C_MINUS = 10;
    localparam int C_BLANK = 11;
    localparam int C_E     = 12;
    localparam int C_R     = 13;
`ifdef LEADING_ZERO_BLANK_EN
    localparam int Z = C_BLANK;
`else
    localparam int Z = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] B;
    logic [6:0] mux_out;
    logic [3:0] decoder_out;

    int         tests = 0;
    int         fails = 0;
    int         dig[4];
    logic [3:0] prev;
    int         scan;
    int         last_k;

    display #(.REFRESH_BITS(RB)) dut (
        .clk(clk),
        .rst(rst),
        .B(B),
        .mux_out(mux_out),
        .decoder_out(decoder_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            C_MINUS: return 7'b0111111;
            C_E:     return 7'b0000110;
            C_R:     return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Character the display should show at position pos for the current digits and buttons.
    function automatic int model_char(input int pos);
        int a, bv, v;
        int ch[4];
        bit neg, res;
        a   = 10 * dig[0] + dig[1];
        bv  = 10 * dig[2] + dig[3];
        v   = 0;
        neg = 1'b0;
        res = 1'b1;
        if (B[8]) res = 1'b0;
        else if (B[7]) begin
            if (bv == 0) begin
                ch = '{C_BLANK, C_E, C_R, C_R};
                return ch[pos];
            end
            v = a / bv;
        end
        else if (B[6]) v = a * bv;
        else if (B[5]) v = a - bv;
        else if (B[4]) v = a + bv;
        else res = 1'b0;
        if (!res) return dig[pos];
        if (v < 0) begin
            neg = 1'b1;
            v   = -v;
        end
        ch[0] = neg ? C_MINUS : (v / 1000) % 10;
        ch[1] = (v / 100) % 10;
        ch[2] = (v / 10) % 10;
        ch[3] = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit lead;
            lead = 1'b1;
            for (int p = (neg ? 1 : 0); p < 3; p++) begin
                if (lead && ch[p] == 0) ch[p] = C_BLANK;
                else lead = 1'b0;
            end
        end
`endif
        return ch[pos];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: predict the pins from the pre-edge state, advance the model, compare.
    task automatic tick();
        int k;
        logic [6:0] es;
        logic [3:0] ea;
        k  = (scan / 4) % 4;
        es = glyph(model_char(k));
        ea = 4'hF;
        ea[3-k] = 1'b0;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) dig[i] = 0;
            prev = B[3:0];
            scan = 0;
            es   = 7'h7F;
            ea   = 4'hF;
        end else begin
            for (int i = 0; i < 4; i++) if (B[i] && !prev[i]) dig[i] = (dig[i] + 1) % 10;
            prev = B[3:0];
            scan = (scan + 1) % 16;
        end
        last_k = k;
        #1;
        check("seg", mux_out, es);
        check("anode", {3'b000, decoder_out}, {3'b000, ea});
    endtask

    task automatic pulse(input logic [3:0] m, input int n);
        repeat (n) begin
            B[3:0] = m;
            tick();
            B[3:0] = 4'b0000;
            tick();
        end
    endtask

    task automatic expect_view(input string tag, input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        repeat (16) begin
            tick();
            check(tag, mux_out, glyph(c[last_k]));
        end
    endtask

    initial begin
        rst  = 1'b1;
        B    = 9'd0;
        prev = 4'd0;
        scan = 0;
        for (int i = 0; i < 4; i++) dig[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("first_p0_anode", {3'b000, decoder_out}, 7'b0000111);
        check("first_p0_seg", mux_out, 7'b1000000);

        pulse(4'b0001, 9); pulse(4'b0010, 9); pulse(4'b0100, 9); pulse(4'b1000, 9);
        expect_view("ops_9999", 9, 9, 9, 9);
        B[8:4] = 5'b00100; expect_view("mul_9801", 9, 8, 0, 1);
        B[8:4] = 5'b00001; expect_view("add_198", Z, 1, 9, 8);
        B[8:4] = 5'b00010; expect_view("sub_zero", Z, Z, Z, 0);
        B[8:4] = 5'b00000; pulse(4'b1000, 9);
        B[8:4] = 5'b00010; expect_view("sub_one", Z, Z, Z, 1);
        B[8:4] = 5'b01000; expect_view("div_one", Z, Z, Z, 1);
        B[8:4] = 5'b10000; expect_view("ops_9998", 9, 9, 9, 8);
        B[8:4] = 5'b11111; expect_view("ops_prio", 9, 9, 9, 8);

        B[8:4] = 5'b00000;
        pulse(4'b0001, 4); pulse(4'b0010, 3); pulse(4'b1100, 2);
        expect_view("ops_3210", 3, 2, 1, 0);
        B[8:4] = 5'b01000; expect_view("div_3", Z, Z, Z, 3);
        B[8:4] = 5'b00010; expect_view("sub_22", Z, Z, 2, 2);
        B[8:4] = 5'b00101; expect_view("mul_prio", Z, 3, 2, 0);
        B[8:4] = 5'b01100; expect_view("div_prio", Z, Z, Z, 3);

        B[8:4] = 5'b00000;
        pulse(4'b0001, 8); pulse(4'b0100, 2); pulse(4'b1000, 4);
        expect_view("ops_1234", 1, 2, 3, 4);
        B[8:4] = 5'b00010; expect_view("sub_neg", C_MINUS, Z, 2, 2);
        B[8:4] = 5'b00000;
        pulse(4'b0100, 7); pulse(4'b1000, 6);
        expect_view("ops_1200", 1, 2, 0, 0);
        B[8:4] = 5'b01000; expect_view("div_zero", C_BLANK, C_E, C_R, C_R);

        // Random button traffic, every cycle checked against the model.
        repeat (300) begin
            B = 9'($urandom_range(0, 511));
            tick();
        end
        repeat (20) begin
            B[8:4] = 5'd0;
            pulse(4'($urandom_range(0, 15)), $urandom_range(1, 6));
            B[8:4] = 5'($urandom_range(0, 31));
            repeat (16) tick();
        end

        // Button held through reset must not count on release.
        B   = 9'h001;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        B = 9'h000;
        expect_view("held_rst", 0, 0, 0, 0);

        // Reset mid-scan discards digits and restarts at P0.
        pulse(4'b0011, 3);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_seg", mux_out, 7'h7F);
        check("rst_anode", {3'b000, decoder_out}, 7'h0F);
        rst = 1'b0;
        tick();
        check("rst_p0", {3'b000, decoder_out}, 7'b0000111);
        expect_view("after_rst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
